// File: rtl/dbus_arbiter.sv
// Two-master data bus arbiter. It grants one requester for a whole transaction,
// from grant to data_ok, and counts completed transactions per port.
package dbus_pkg;
  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        dreq0,
  output dbus_resp_t       dresp0,
  input  dbus_req_t        dreq1,
  output dbus_resp_t       dresp1,
  output dbus_req_t        oreq,
  input  dbus_resp_t       oresp,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_reg;
  logic       last_reg;
  dbus_req_t  lreq_reg;

  logic       grant;
  logic       win;
  logic       cur;
  logic       active;
  logic       done;
  logic       cur_valid;
  dbus_resp_t rsp;

  always_comb begin
    grant = (state_reg == IDLE) && (dreq0.valid || dreq1.valid);
    if (dreq0.valid && dreq1.valid) win = FIXED_PRIO ? 1'b0 : ~last_reg;
    else                            win = dreq1.valid;
    cur       = (state_reg == IDLE) ? win : (state_reg == BUSY1);
    active    = grant || (state_reg != IDLE);
    done      = active && oresp.data_ok;
    cur_valid = cur ? dreq1.valid : dreq0.valid;
  end

  // In BUSY the bus sees only the latched copy, so requester changes cannot leak through.
  always_comb begin
    oreq = '0;
    if (!reset) begin
      if (state_reg != IDLE) oreq = lreq_reg;
      else if (grant)        oreq = win ? dreq1 : dreq0;
    end
  end

  always_comb begin
    rsp = '0;
    if (!reset && active) begin
      rsp.data    = oresp.data;
      rsp.addr_ok = oresp.addr_ok & cur_valid;
      rsp.data_ok = oresp.data_ok & cur_valid;
    end
    dresp0 = cur ? '0 : rsp;
    dresp1 = cur ? rsp : '0;
  end

  assign busy  = (state_reg != IDLE);
  assign owner = grant ? win : last_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      lreq_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            last_reg <= win;
            lreq_reg <= win ? dreq1 : dreq0;
            if (!oresp.data_ok) state_reg <= win ? BUSY1 : BUSY0;
          end
        end
        BUSY0, BUSY1: begin
          if (oresp.data_ok) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                        cnt_reg <= '0;
        else if (done && cur == 1'(gi))   cnt_reg <= cnt_reg + CNT_ONE;
      end

      if (gi == 0) begin : g_out0
        assign done_cnt0 = cnt_reg;
      end else begin : g_out1
        assign done_cnt1 = cnt_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: round-robin and fixed-priority instances
// behind a shared slave model; expected completions are queued by the driver.
module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam logic [63:0] K = 64'h0F0F_0000_0000_F0F0;

  typedef struct {
    logic        port;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic        ok;
    logic        aok;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic stray_ok = 1'b0;
  int   lat = 0;
  int   wait_cnt;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   last_done_cyc = 0;
  logic chk_busy_next = 1'b0;
  exp_t expq[$];

  dbus_req_t  dreq0, dreq1;
  dbus_req_t  dreq0_a, dreq1_a, dreq0_b, dreq1_b, oreq_a, oreq_b, oreq_m;
  dbus_resp_t dresp0_a, dresp1_a, dresp0_b, dresp1_b, dresp0_m, dresp1_m;
  dbus_resp_t oresp_a, oresp_b, oresp_m;
  logic       busy_a, busy_b, busy_m, owner_a, owner_b, owner_m;
  logic [31:0] cnt0_a, cnt1_a, cnt0_b, cnt1_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dreq0_a  = sel ? '0 : dreq0;
  assign dreq1_a  = sel ? '0 : dreq1;
  assign dreq0_b  = sel ? dreq0 : '0;
  assign dreq1_b  = sel ? dreq1 : '0;
  assign oresp_a  = sel ? '0 : oresp_m;
  assign oresp_b  = sel ? oresp_m : '0;
  assign oreq_m   = sel ? oreq_b : oreq_a;
  assign dresp0_m = sel ? dresp0_b : dresp0_a;
  assign dresp1_m = sel ? dresp1_b : dresp1_a;
  assign busy_m   = sel ? busy_b : busy_a;
  assign owner_m  = sel ? owner_b : owner_a;

  dbus_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(32)) u_rr (
    .clk(clk), .reset(reset), .dreq0(dreq0_a), .dresp0(dresp0_a), .dreq1(dreq1_a),
    .dresp1(dresp1_a), .oreq(oreq_a), .oresp(oresp_a), .busy(busy_a), .owner(owner_a),
    .done_cnt0(cnt0_a), .done_cnt1(cnt1_a));

  dbus_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(32)) u_fp (
    .clk(clk), .reset(reset), .dreq0(dreq0_b), .dresp0(dresp0_b), .dreq1(dreq1_b),
    .dresp1(dresp1_b), .oreq(oreq_b), .oresp(oresp_b), .busy(busy_b), .owner(owner_b),
    .done_cnt0(cnt0_b), .done_cnt1(cnt1_b));

  // Slave: accepts in the first cycle, completes after lat wait cycles.
  always_comb begin
    oresp_m = '0;
    oresp_m.data    = oreq_m.addr ^ K;
    oresp_m.addr_ok = oreq_m.valid && (wait_cnt == 0);
    oresp_m.data_ok = (oreq_m.valid && (wait_cnt == lat)) || stray_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= 0;
    else if (oresp_m.data_ok) wait_cnt <= 0;
    else if (oreq_m.valid)    wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input dbus_req_t r, input logic ok, input logic aok);
    exp_t e;
    e.port = port; e.addr = r.addr; e.size = r.size; e.strobe = r.strobe;
    e.wdata = r.data; e.ok = ok; e.aok = aok; e.rdata = r.addr ^ K;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input string name);
    int target = done_seen + n;
    int b = 0;
    while (done_seen < target && b < 200) begin
      step();
      b++;
    end
    if (done_seen < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d completions expected %0d", name, done_seen, target);
    end
  endtask

  task automatic do_reset();
    dreq0 = '0;
    dreq1 = '0;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic dbus_req_t mk(input logic [63:0] a, input msize_t s,
                                   input logic [7:0] st, input logic [63:0] d);
    dbus_req_t r;
    r.valid = 1'b1; r.addr = a; r.size = s; r.strobe = st; r.data = d;
    return r;
  endfunction

  // Monitor: pops one expectation per completed bus transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_busy_next) begin
        chk("busy_after_done", 128'(busy_m), 128'(0));
        chk_busy_next = 1'b0;
      end
      if (oreq_m.valid && oresp_m.data_ok) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got completion at addr %0h expected none", oreq_m.addr);
        end else begin
          e = expq.pop_front();
          chk("owner", 128'(owner_m), 128'(e.port));
          chk("oreq_addr", 128'(oreq_m.addr), 128'(e.addr));
          chk("oreq_size", 128'(oreq_m.size), 128'(e.size));
          chk("oreq_strobe", 128'(oreq_m.strobe), 128'(e.strobe));
          chk("oreq_data", 128'(oreq_m.data), 128'(e.wdata));
          chk("resp_data_ok", 128'(e.port ? dresp1_m.data_ok : dresp0_m.data_ok), 128'(e.ok));
          chk("resp_addr_ok", 128'(e.port ? dresp1_m.addr_ok : dresp0_m.addr_ok), 128'(e.aok));
          chk("resp_data", 128'(e.port ? dresp1_m.data : dresp0_m.data), 128'(e.rdata));
          chk("nonowner_zero", 128'(e.port ? dresp0_m : dresp1_m), 128'(0));
        end
        done_seen++;
        last_done_cyc = cyc;
        chk_busy_next = 1'b1;
      end else if (dresp0_m.data_ok || dresp1_m.data_ok) begin
        checks++;
        failures++;
        $display("FAIL stray_dresp: got data_ok %0b/%0b expected 0/0", dresp0_m.data_ok, dresp1_m.data_ok);
      end
    end
  end

  initial begin
    int c0;
    int d0;
    dreq0 = mk(64'h9000, MSIZE8, 8'h00, 64'h0);
    dreq1 = '0;
    #3;
    chk("rst_oreq_valid", 128'(oreq_m.valid), 128'(0));
    chk("rst_dresp0", 128'(dresp0_m), 128'(0));
    dreq0 = '0;
    step();
    reset = 1'b0;
    #3;
    chk("rst_busy", 128'(busy_m), 128'(0));
    chk("rst_owner", 128'(owner_m), 128'(1));
    chk("rst_cnt0", 128'(cnt0_a), 128'(0));

    // 1: single port-0 load, 3 wait cycles
    do_reset();
    lat = 3;
    dreq0 = mk(64'h8000_0008, MSIZE8, 8'h00, 64'h0);
    push(1'b0, dreq0, 1'b1, 1'b0);
    c0 = cyc;
    wait_done(1, "t1");
    dreq0 = '0;
    chk("t1_latency", 128'(last_done_cyc - c0), 128'(3));
    chk("t1_cnt0", 128'(cnt0_a), 128'(1));
    chk("t1_cnt1", 128'(cnt1_a), 128'(0));

    // 2: both always valid, round-robin
    do_reset();
    lat = 2;
    dreq0 = mk(64'h1000, MSIZE4, 8'h00, 64'h0);
    dreq1 = mk(64'h2000, MSIZE4, 8'hF0, 64'h1234);
    for (int i = 0; i < 4; i++) push(i[0], (i[0] ? dreq1 : dreq0), 1'b1, 1'b0);
    wait_done(4, "t2");
    dreq0 = '0;
    dreq1 = '0;
    chk("t2_cnt0", 128'(cnt0_a), 128'(2));
    chk("t2_cnt1", 128'(cnt1_a), 128'(2));

    // 4: flushed port-1 store, latched request must stay on the bus
    do_reset();
    lat = 4;
    dreq1 = mk(64'h5000, MSIZE4, 8'h0F, 64'hDEAD_BEEF);
    push(1'b1, dreq1, 1'b0, 1'b0);
    step();
    step();
    dreq1 = '0;
    #3;
    chk("t4_hold_valid", 128'(oreq_m.valid), 128'(1));
    chk("t4_hold_addr", 128'(oreq_m.addr), 128'(64'h5000));
    chk("t4_hold_data", 128'(oreq_m.data), 128'(64'hDEAD_BEEF));
    chk("t4_hold_strobe", 128'(oreq_m.strobe), 128'(8'h0F));
    chk("t4_busy", 128'(busy_m), 128'(1));
    wait_done(1, "t4");
    chk("t4_cnt1", 128'(cnt1_a), 128'(1));
    chk("t4_cnt0", 128'(cnt0_a), 128'(0));

    // 5: zero-wait slave, alternating ports
    do_reset();
    lat = 0;
    d0 = done_seen;
    for (int i = 0; i < 4; i++) begin
      dreq0 = '0;
      dreq1 = '0;
      if (i[0]) dreq1 = mk(64'h6000 + 64'(i * 8), MSIZE8, 8'hFF, 64'h0000_0000_CAFE_0000 + 64'(i));
      else      dreq0 = mk(64'h6000 + 64'(i * 8), MSIZE8, 8'h00, 64'h0);
      push(i[0], (i[0] ? dreq1 : dreq0), 1'b1, 1'b1);
      #3;
      chk("t5_busy", 128'(busy_m), 128'(0));
      step();
    end
    dreq0 = '0;
    dreq1 = '0;
    #3;
    chk("t5_busy_end", 128'(busy_m), 128'(0));
    chk("t5_done", 128'(done_seen - d0), 128'(4));
    chk("t5_cnt0", 128'(cnt0_a), 128'(2));
    chk("t5_cnt1", 128'(cnt1_a), 128'(2));

    // 6: reset in the middle of BUSY0, then a stray data_ok
    do_reset();
    lat = 10;
    dreq0 = mk(64'h7000, MSIZE8, 8'h00, 64'h0);
    step();
    step();
    #3;
    chk("t6_busy", 128'(busy_m), 128'(1));
    step();
    reset = 1'b1;
    #3;
    chk("t6_oreq_valid", 128'(oreq_m.valid), 128'(0));
    chk("t6_dresp0", 128'(dresp0_m), 128'(0));
    chk("t6_busy_rst", 128'(busy_m), 128'(0));
    step();
    dreq0 = '0;
    step();
    reset = 1'b0;
    step();
    stray_ok = 1'b1;
    #3;
    chk("t6_stray_dresp0", 128'(dresp0_m), 128'(0));
    chk("t6_stray_dresp1", 128'(dresp1_m), 128'(0));
    step();
    stray_ok = 1'b0;
    chk("t6_cnt0", 128'(cnt0_a), 128'(0));
    chk("t6_cnt1", 128'(cnt1_a), 128'(0));

    // 3: fixed priority, port 0 always valid
    sel = 1'b1;
    do_reset();
    lat = 1;
    dreq0 = mk(64'h3000, MSIZE2, 8'h03, 64'h55);
    dreq1 = mk(64'h4000, MSIZE2, 8'h00, 64'h0);
    for (int i = 0; i < 3; i++) push(1'b0, dreq0, 1'b1, 1'b0);
    wait_done(3, "t3");
    dreq0 = '0;
    dreq1 = '0;
    chk("t3_cnt0", 128'(cnt0_b), 128'(3));
    chk("t3_cnt1", 128'(cnt1_b), 128'(0));

    step();
    step();
    chk("queue_empty", 128'(expq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
